// File: rtl/uart_pkg.sv
// Shared constants, state type and timing helper for the UART transmit path.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  // Clock cycles per bit, truncated; the top level rejects results below 2.
  function automatic int calc_div(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through head, occupancy level and
// full/empty flags; a push while full is refused even when a pop coincides.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with configurable data bits, parity and stop bits.
// Define UART_TX_FIFO_BREAK_EN to add the break_req input and line-break state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int DEPTH           = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_done
`ifdef UART_TX_FIFO_BREAK_EN
  ,
  input  logic                   break_req
`endif
);

  localparam int DIV        = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW         = $clog2(DIV);
  localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != PARITY_NONE) ? 1 : 0) + STOP_BITS;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [4:0]    DATA_LAST = 5'(DATA_BITS - 1);
  localparam logic [4:0]    STOP_LAST = 5'(STOP_BITS - 1);
`ifdef UART_TX_FIFO_BREAK_EN
  localparam logic [4:0]    BREAK_LOW = 5'(2 * FRAME_BITS);
`endif

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  tx_state_t              state;
  tx_state_t              state_d;
  logic [CW-1:0]          baud_cnt;
  logic [CW-1:0]          baud_d;
  logic [4:0]             bit_cnt;
  logic [4:0]             bit_d;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   shift_d;
  logic                   par;
  logic                   par_d;
  logic                   tx_d;
  logic                   running;
  logic                   push;
  logic                   pop;
  logic                   bit_end;
  logic                   head_par;
  logic [DATA_BITS-1:0]   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (in_data),
    .wr_en   (push),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // running holds in_ready low for the cycle in which reset is sampled.
  assign in_ready = running && !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign busy     = (state != ST_IDLE) || (level != '0);
  assign head_par = (^fifo_head) ^ (PARITY == PARITY_ODD);

  always_comb begin
    state_d    = state;
    baud_d     = bit_end ? '0 : baud_cnt + 1'b1;
    bit_d      = bit_cnt;
    shift_d    = shift;
    par_d      = par;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_d = '0;
`ifdef UART_TX_FIFO_BREAK_EN
        if (break_req) begin
          state_d = ST_BREAK;
          bit_d   = '0;
        end else
`endif
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          par_d   = head_par;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      // The next queued byte starts immediately so back-to-back frames have no gap.
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            bit_d      = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_head;
              par_d   = head_par;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_FIFO_BREAK_EN
      ST_BREAK: begin
        if (bit_end) begin
          if (bit_cnt == BREAK_LOW) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next state so it changes on the same edge as the FSM.
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
`ifdef UART_TX_FIFO_BREAK_EN
      ST_BREAK:  tx_d = (bit_d == BREAK_LOW);
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      running  <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      par      <= par_d;
      tx       <= tx_d;
      running  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance and a 7E2 instance, both DEPTH 4.
// Define UART_TX_FIFO_BREAK_EN to also exercise the line-break feature.
module tb_uart_tx_fifo;

  localparam int DIV_A = 4;
  localparam int DIV_B = 3;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] a_in_data;
  logic       a_in_valid;
  logic       a_in_ready;
  logic       a_tx;
  logic       a_busy;
  logic [2:0] a_level;
  logic       a_frame_done;
  logic       a_break_req;

  logic [6:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready;
  logic       b_tx;
  logic       b_busy;
  logic [2:0] b_level;
  logic       b_frame_done;
  logic       b_break_req;

  int checks   = 0;
  int failures = 0;

  logic [8:0] hello [5];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (40),
    .BAUD_RATE       (10),
    .DATA_BITS       (8),
    .PARITY          (0),
    .STOP_BITS       (1),
    .DEPTH           (4)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .tx         (a_tx),
    .busy       (a_busy),
    .level      (a_level),
    .frame_done (a_frame_done)
`ifdef UART_TX_FIFO_BREAK_EN
    ,
    .break_req  (a_break_req)
`endif
  );

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (30),
    .BAUD_RATE       (10),
    .DATA_BITS       (7),
    .PARITY          (2),
    .STOP_BITS       (2),
    .DEPTH           (4)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .tx         (b_tx),
    .busy       (b_busy),
    .level      (b_level),
    .frame_done (b_frame_done)
`ifdef UART_TX_FIFO_BREAK_EN
    ,
    .break_req  (b_break_req)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic valid, input logic [8:0] data);
    if (which == 0) begin
      a_in_valid = valid;
      a_in_data  = data[7:0];
    end else begin
      b_in_valid = valid;
      b_in_data  = data[6:0];
    end
  endtask

  function automatic logic txOf(input int which);
    return (which == 0) ? a_tx : b_tx;
  endfunction

  // Polls on negedges until tx is low or the budget runs out.
  task automatic waitStart(input int which, input int budget, input string tag);
    int n;
    n = 0;
    while (txOf(which) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".start_seen"}, 32'(n < budget), 32'd1);
  endtask

  // Called at the negedge of frame cycle first_cycle; checks every cycle of each bit.
  task automatic checkFrame(input int which, input logic [8:0] data, input string tag, input int first_cycle);
    int         div;
    int         nbits;
    int         fd_count;
    int         k;
    logic [15:0] bits;
    logic [7:0]  obs;
    logic [7:0]  want;
    logic        fd;
    logic        fd_last;
    if (which == 0) begin
      div   = DIV_A;
      nbits = 10;
      bits  = {6'b0, 1'b1, data[7:0], 1'b0};
    end else begin
      div   = DIV_B;
      nbits = 11;
      bits  = {5'b0, 2'b11, ^data[6:0], data[6:0], 1'b0};
    end
    fd_count = 0;
    fd_last  = 1'b0;
    k        = first_cycle / div;
    want     = bits[k] ? 8'hFF : 8'h00;
    obs      = want;
    for (int c = first_cycle; c < nbits * div; c++) begin
      if (c != first_cycle) @(negedge clk);
      if (c % div == 0) begin
        k    = c / div;
        want = bits[k] ? 8'hFF : 8'h00;
        obs  = want;
      end
      obs[c % div] = txOf(which);
      fd = (which == 0) ? a_frame_done : b_frame_done;
      if (fd === 1'b1) fd_count++;
      fd_last = fd;
      if (c % div == div - 1)
        checkOutput($sformatf("%s.bit%0d", tag, k), 32'(obs), 32'(want));
    end
    checkOutput({tag, ".frame_done_last"}, 32'(fd_last), 32'd1);
    checkOutput({tag, ".frame_done_count"}, 32'(fd_count), 32'd1);
  endtask

  initial begin
    int lows;
    int highs;
    int fds;
    hello       = '{9'h48, 9'h65, 9'h6C, 9'h6C, 9'h6F};
    rst_n       = 1'b0;
    a_break_req = 1'b0;
    b_break_req = 1'b0;
    applyStimulus(0, 1'b0, 9'h0);
    applyStimulus(1, 1'b0, 9'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.a_tx", 32'(a_tx), 32'd1);
    checkOutput("rst.a_in_ready", 32'(a_in_ready), 32'd0);
    checkOutput("rst.a_busy", 32'(a_busy), 32'd0);
    checkOutput("rst.a_level", 32'(a_level), 32'd0);
    checkOutput("rst.a_frame_done", 32'(a_frame_done), 32'd0);
    checkOutput("rst.b_tx", 32'(b_tx), 32'd1);
    checkOutput("rst.b_in_ready", 32'(b_in_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst.a_in_ready", 32'(a_in_ready), 32'd1);
    checkOutput("post_rst.b_in_ready", 32'(b_in_ready), 32'd1);

    // Single 0x48 on the 8N1 instance: tx low from the edge after acceptance
    @(posedge clk); #1 applyStimulus(0, 1'b1, 9'h48);
    @(posedge clk); #1 applyStimulus(0, 1'b0, 9'h0);
    @(negedge clk);
    checkOutput("h48.level", 32'(a_level), 32'd1);
    checkOutput("h48.tx_before", 32'(a_tx), 32'd1);
    checkOutput("h48.busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    checkFrame(0, 9'h48, "h48", 0);
    @(negedge clk);
    checkOutput("h48.busy_after", 32'(a_busy), 32'd0);
    checkOutput("h48.tx_after", 32'(a_tx), 32'd1);

    // 0x55 on the 7E2 instance: 0,1010101,parity 0,1,1
    @(posedge clk); #1 applyStimulus(1, 1'b1, 9'h55);
    @(posedge clk); #1 applyStimulus(1, 1'b0, 9'h0);
    @(negedge clk);
    checkOutput("b55.tx_before", 32'(b_tx), 32'd1);
    @(negedge clk);
    checkFrame(1, 9'h55, "b55", 0);
    @(negedge clk);
    checkOutput("b55.busy_after", 32'(b_busy), 32'd0);

    // "Hello" in 5 consecutive cycles on the 7E2 instance, frames back to back
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, hello[i]);
      @(negedge clk);
      checkOutput($sformatf("hello.in_ready%0d", i), 32'(b_in_ready), 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(1, 1'b0, 9'h0);
    @(negedge clk);
    checkOutput("hello.level_peak", 32'(b_level), 32'd4);
    checkOutput("hello.in_ready_full", 32'(b_in_ready), 32'd0);
    checkFrame(1, hello[0], "hello0", 3);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      checkFrame(1, hello[i], $sformatf("hello%0d", i), 0);
    end
    @(negedge clk);
    checkOutput("hello.busy_after", 32'(b_busy), 32'd0);

    // Hold in_valid 10 cycles on the DEPTH 4 instance: 5 accepted, 5 refused
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1'b1, 9'(9'hA0 + i));
      @(negedge clk);
      checkOutput($sformatf("ovf.in_ready%0d", i), 32'(a_in_ready), 32'(i < 5));
      @(posedge clk); #1;
    end
    applyStimulus(0, 1'b0, 9'h0);
    @(negedge clk);
    checkOutput("ovf.level_full", 32'(a_level), 32'd4);
    checkFrame(0, 9'hA0, "ovf0", 8);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      checkFrame(0, 9'(9'hA0 + i), $sformatf("ovf%0d", i), 0);
    end
    @(negedge clk);
    checkOutput("ovf.busy_after", 32'(a_busy), 32'd0);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_tx !== 1'b1) lows++;
    end
    checkOutput("ovf.no_refused_frames", 32'(lows), 32'd0);

    // Reset mid-DATA with 3 bytes queued
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 9'(9'h31 + i));
      @(posedge clk); #1;
    end
    applyStimulus(0, 1'b0, 9'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst.level_before", 32'(a_level), 32'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst.tx", 32'(a_tx), 32'd1);
    checkOutput("midrst.level", 32'(a_level), 32'd0);
    checkOutput("midrst.busy", 32'(a_busy), 32'd0);
    checkOutput("midrst.in_ready", 32'(a_in_ready), 32'd0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (a_tx !== 1'b1) lows++;
    end
    checkOutput("midrst.no_frames", 32'(lows), 32'd0);
    checkOutput("midrst.busy_later", 32'(a_busy), 32'd0);

`ifdef UART_TX_FIFO_BREAK_EN
    // Break while idle with a byte queued: 20 bit times low, one high, then the frame
    @(posedge clk); #1;
    a_break_req = 1'b1;
    applyStimulus(0, 1'b1, 9'h5A);
    @(posedge clk); #1;
    a_break_req = 1'b0;
    applyStimulus(0, 1'b0, 9'h0);
    lows = 0;
    fds  = 0;
    repeat (20 * DIV_A) begin
      @(negedge clk);
      if (a_tx === 1'b0) lows++;
      if (a_frame_done === 1'b1) fds++;
    end
    checkOutput("brk.low_cycles", 32'(lows), 32'(20 * DIV_A));
    highs = 0;
    repeat (DIV_A) begin
      @(negedge clk);
      if (a_tx === 1'b1) highs++;
      if (a_frame_done === 1'b1) fds++;
    end
    checkOutput("brk.high_cycles", 32'(highs), 32'(DIV_A));
    checkOutput("brk.no_frame_done", 32'(fds), 32'd0);
    checkOutput("brk.level_pending", 32'(a_level), 32'd1);
    @(negedge clk);
    waitStart(0, 8, "brk");
    checkFrame(0, 9'h5A, "brk5a", 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
